// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out serializer. Takes one INWIDTH word per handshake and streams
// it out as OUTWIDTH chunks, either MSB-first or LSB-first, with a per-word length.
module piso_stream_serializer #(
  parameter int INWIDTH   = 32,
  parameter int OUTWIDTH  = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int NCHUNK   = INWIDTH / OUTWIDTH,
  localparam int CW       = $clog2(NCHUNK + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INWIDTH-1:0]  in_data,
  input  logic [CW-1:0]       in_len,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUTWIDTH-1:0] out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  input  logic                flush
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_SEND   = 1'b1;
  localparam logic [CW-1:0] NCHUNK_C = CW'(NCHUNK);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [0:0]         state_q, state_d;
  logic [INWIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      len_norm;
  logic               beat, load, is_last;

  assign out_valid = (state_q == S_SEND);
  assign is_last   = (count_q == ONE_C);
  assign out_last  = out_valid & is_last;
  assign beat      = out_valid & out_ready;
  // Only a finishing last beat frees the register for a zero-bubble reload.
  assign in_ready  = ~rst & ~flush & ((state_q == S_IDLE) | (beat & is_last));
  assign load      = in_valid & in_ready;
  assign len_norm  = ((in_len == '0) || (in_len > NCHUNK_C)) ? NCHUNK_C : in_len;

  generate
    if (MSB_FIRST) begin : g_msb
      assign out_data = shift_q[INWIDTH-1 -: OUTWIDTH];
    end else begin : g_lsb
      assign out_data = shift_q[OUTWIDTH-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    if (flush) begin
      state_d = S_IDLE;
      shift_d = '0;
      count_d = '0;
    end else if (load) begin
      state_d = S_SEND;
      shift_d = in_data;
      count_d = len_norm;
    end else if (beat) begin
      if (is_last) begin
        state_d = S_IDLE;
        shift_d = '0;
        count_d = '0;
      end else begin
        if (MSB_FIRST) shift_d = shift_q << OUTWIDTH;
        else           shift_d = shift_q >> OUTWIDTH;
        count_d = count_q - ONE_C;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  a_count_nonzero: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_SEND) |-> (count_q != '0));

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Directed bench: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_piso_stream_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [2:0]  in_len;
  logic        in_valid, out_ready, flush;
  logic        in_ready_m, out_valid_m, out_last_m;
  logic        in_ready_l, out_valid_l, out_last_l;
  logic [7:0]  out_data_m, out_data_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_stream_serializer #(.INWIDTH(32), .OUTWIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_data(out_data_m), .out_valid(out_valid_m),
    .out_last(out_last_m), .out_ready(out_ready), .flush(flush));

  piso_stream_serializer #(.INWIDTH(32), .OUTWIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_data(out_data_l), .out_valid(out_valid_l),
    .out_last(out_last_l), .out_ready(out_ready), .flush(flush));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one handshake edge; afterwards the first chunk is visible.
  task automatic load_word(input logic [31:0] d, input logic [2:0] len);
    in_data  = d;
    in_len   = len;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_len = '0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    step();
    checks++;
    if ({out_valid_m, out_last_m, out_data_m, in_ready_m} !== 11'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h rdy=%b, want all 0",
               out_valid_m, out_last_m, out_data_m, in_ready_m);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (in_ready_m !== 1'b1 || in_ready_l !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b/%b, want 1/1", in_ready_m, in_ready_l);
    end
  endtask

  task automatic test_msb_full();
    logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    load_word(32'hDEADBEEF, 3'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid_m !== 1'b1 || out_data_m !== exp[i] || out_last_m !== (i == 3)) begin
        failures++;
        $display("FAIL msb_full beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, out_valid_m, out_data_m, out_last_m, exp[i], (i == 3));
      end
      step();
    end
    checks++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
      failures++;
      $display("FAIL msb_full_idle: got v=%b rdy=%b, want v=0 rdy=1", out_valid_m, in_ready_m);
    end
  endtask

  task automatic test_lsb_and_len();
    logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_word(32'hDEADBEEF, 3'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid_l !== 1'b1 || out_data_l !== exp[i] || out_last_l !== (i == 3)) begin
        failures++;
        $display("FAIL lsb_full beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, out_valid_l, out_data_l, out_last_l, exp[i], (i == 3));
      end
      step();
    end
    load_word(32'hDEADBEEF, 3'd2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid_l !== 1'b1 || out_data_l !== exp[i] || out_last_l !== (i == 1)) begin
        failures++;
        $display("FAIL lsb_len2 beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, out_valid_l, out_data_l, out_last_l, exp[i], (i == 1));
      end
      step();
    end
    checks++;
    if (out_valid_l !== 1'b0) begin
      failures++;
      $display("FAIL lsb_len2_idle: got v=%b, want 0", out_valid_l);
    end
  endtask

  // in_len beyond the chunk count behaves like a full word.
  task automatic test_len_norm();
    logic [7:0] exp [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    load_word(32'h12345678, 3'd7);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid_m !== 1'b1 || out_data_m !== exp[i] || out_last_m !== (i == 3)) begin
        failures++;
        $display("FAIL len7 beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, out_valid_m, out_data_m, out_last_m, exp[i], (i == 3));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3] = '{8'hAD, 8'hBE, 8'hEF};
    load_word(32'hDEADBEEF, 3'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid_m !== 1'b1 || out_data_m !== 8'hDE || out_last_m !== 1'b0) begin
        failures++;
        $display("FAIL stall%0d: got v=%b d=%h l=%b, want v=1 d=de l=0",
                 i, out_valid_m, out_data_m, out_last_m);
      end
    end
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_data_m !== exp[i] || out_last_m !== (i == 2)) begin
        failures++;
        $display("FAIL post_stall beat%0d: got d=%h l=%b, want d=%h l=%b",
                 i, out_data_m, out_last_m, exp[i], (i == 2));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    in_data = 32'h01020304; in_len = 3'd0; in_valid = 1'b1;
    step();
    in_data = 32'hA0B0C0D0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid_m !== 1'b1 || out_data_m !== exp[i] || out_last_m !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL b2b beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, out_valid_m, out_data_m, out_last_m, exp[i], (i == 3 || i == 7));
      end
      if (i < 7) begin
        checks++;
        if (in_ready_m !== (i == 3)) begin
          failures++;
          $display("FAIL b2b_ready beat%0d: got %b, want %b", i, in_ready_m, (i == 3));
        end
      end
      step();
      if (i == 3) in_valid = 1'b0;
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_word(32'hDEADBEEF, 3'd0);
    step();
    flush = 1'b1; in_data = 32'h11223344; in_len = 3'd0; in_valid = 1'b1;
    #1;
    checks++;
    if (out_data_m !== 8'hAD || in_ready_m !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle: got d=%h rdy=%b, want d=ad rdy=0", out_data_m, in_ready_m);
    end
    step();
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle: got v=%b rdy=%b, want v=0 rdy=1", out_valid_m, in_ready_m);
    end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid_m !== 1'b1 || out_data_m !== exp[i]) begin
        failures++;
        $display("FAIL post_flush beat%0d: got v=%b d=%h, want v=1 d=%h",
                 i, out_valid_m, out_data_m, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    load_word(32'hDEADBEEF, 3'd0);
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid_m, out_last_m, out_data_m, in_ready_m, out_valid_l, out_data_l} !== 20'h0) begin
      failures++;
      $display("FAIL async_rst: got v=%b l=%b d=%h rdy=%b lv=%b ld=%h, want all 0",
               out_valid_m, out_last_m, out_data_m, in_ready_m, out_valid_l, out_data_l);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid_m !== 1'b0 || out_data_m !== 8'h00 || in_ready_m !== 1'b1) begin
        failures++;
        $display("FAIL post_rst%0d: got v=%b d=%h rdy=%b, want v=0 d=00 rdy=1",
                 i, out_valid_m, out_data_m, in_ready_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_full();
    test_lsb_and_len();
    test_len_norm();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
